// File: rtl/dkong_dma.sv
// -----------------------------------------------------------------------------
// dkong_dma : byte-copy DMA engine for the Donkey Kong system bus.
//
// The CPU programs source, destination and byte count through an 8-byte
// register window. Once armed and requested by dma_rdy, the engine requests
// the bus, copies CNT bytes one read/write pair at a time, releases the bus
// and pulses done.
//
// Ports
//   masterclk  system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   ena        register-window select, offset = ibus.addr[2:0]
//   ibus       CPU master bus (register writes use addr, dmaster, wrn)
//   obus       register read data, mwait tied high
//   dma_rdy    transfer request level
//   busrq_n    bus request to the CPU (active low)
//   busak_n    bus acknowledge from the CPU (active low)
//   mbus       DMA master bus (addr, dmaster, rdn, wrn, inta)
//   sbus       slave bus read data and wait
//   msel       high while the DMA owns the bus
//   done       one-cycle pulse at the end of a transfer
//
// Configuration
//   DKONG_DMA_READBACK_EN  when defined, registers read back through obus;
//                          otherwise obus.dslave is FFh and no read mux exists.
// -----------------------------------------------------------------------------

package z80_bus_pkg;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dmaster;
    logic        rdn;
    logic        wrn;
    logic        inta;
  } Z80MasterBus;

  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;
endpackage

module dkong_dma
  import z80_bus_pkg::*;
#(
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic        masterclk,
  input  logic        rst_n,
  input  logic        ena,
  input  Z80MasterBus ibus,
  output Z80SlaveBus  obus,
  input  logic        dma_rdy,
  output logic        busrq_n,
  input  logic        busak_n,
  output Z80MasterBus mbus,
  input  Z80SlaveBus  sbus,
  output logic        msel,
  output logic        done
);

  localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_NEXT, S_REL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q;      // strobe-low cycles completed in RD / WR
  logic          wr_act_q;   // 0 = turnaround cycle at the start of WR
  logic [7:0]    data_q;
  logic [15:0]   src_q, dst_q, cnt_q;
  logic          arm_q;
  logic [15:0]   addr_q;     // last driven address, held while not in RD/WR
  logic [15:0]   addr_out;
  logic          rd_last, wr_last;
  logic          unused_ibus_bits;

  assign unused_ibus_bits = ^{ibus.addr[15:3], ibus.rdn, ibus.inta};

  assign rd_last = sbus.mwait && (cyc_q == RD_LAST);
  assign wr_last = wr_act_q && sbus.mwait && (cyc_q == WR_LAST);

  // NOTE: every variable driven here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (arm_q && dma_rdy) state_d = S_REQ;
      // An empty transfer never waits for the grant.
      S_REQ:  if (cnt_q == 16'd0) state_d = S_REL;
              else if (!busak_n) state_d = S_RD;
      S_RD:   if (rd_last) state_d = S_WR;
      S_WR:   if (wr_last) state_d = S_NEXT;
      // cnt_q == 1 means the count reaches zero on this decrement.
      S_NEXT: state_d = (cnt_q == 16'd1) ? S_REL : S_RD;
      S_REL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decode the state directly so that an asynchronous reset
  // drops strobes and releases the bus without waiting for a clock edge.
  always_comb begin
    busrq_n = 1'b1;
    msel    = 1'b0;
    addr_out = addr_q;
    unique case (state_q)
      S_REQ:  busrq_n = 1'b0;
      S_RD:   begin busrq_n = 1'b0; msel = 1'b1; addr_out = src_q; end
      S_WR:   begin busrq_n = 1'b0; msel = 1'b1; addr_out = dst_q; end
      S_NEXT: begin busrq_n = 1'b0; msel = 1'b1; end
      default: ;
    endcase
    done = (state_q == S_REL);
    mbus = '{addr:    addr_out,
             dmaster: data_q,
             rdn:     (state_q != S_RD),
             wrn:     !((state_q == S_WR) && wr_act_q),
             inta:    1'b1};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the register file is a handful of flops, not a RAM, so all of it
  // is reset; software may read it back immediately after reset.
  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q    <= '0;
      wr_act_q <= 1'b0;
      data_q   <= 8'h00;
      src_q    <= 16'h0000;
      dst_q    <= 16'h0000;
      cnt_q    <= 16'h0000;
      arm_q    <= 1'b0;
      addr_q   <= 16'h0000;
    end else begin
      addr_q <= addr_out;
      unique case (state_q)
        S_IDLE: begin
          if (ena && !ibus.wrn) begin
            unique case (ibus.addr[2:0])
              3'd0: src_q[7:0]  <= ibus.dmaster;
              3'd1: src_q[15:8] <= ibus.dmaster;
              3'd2: dst_q[7:0]  <= ibus.dmaster;
              3'd3: dst_q[15:8] <= ibus.dmaster;
              3'd4: cnt_q[7:0]  <= ibus.dmaster;
              3'd5: cnt_q[15:8] <= ibus.dmaster;
              3'd6: arm_q       <= ibus.dmaster[0];
              default: ;
            endcase
          end
        end
        // The strobe count only advances while the slave is not waiting.
        S_RD: begin
          if (sbus.mwait) begin
            if (rd_last) begin
              data_q <= sbus.dslave;
              cyc_q  <= '0;
            end else begin
              cyc_q <= cyc_q + CW'(1);
            end
          end
        end
        S_WR: begin
          if (!wr_act_q) begin
            wr_act_q <= 1'b1;
          end else if (sbus.mwait) begin
            if (wr_last) begin
              cyc_q    <= '0;
              wr_act_q <= 1'b0;
            end else begin
              cyc_q <= cyc_q + CW'(1);
            end
          end
        end
        S_NEXT: begin
          src_q <= src_q + 16'd1;
          dst_q <= dst_q + 16'd1;
          cnt_q <= cnt_q - 16'd1;
        end
        S_REL: arm_q <= 1'b0;
        default: ;
      endcase
    end
  end

  logic [7:0] rd_data;

`ifdef DKONG_DMA_READBACK_EN
  always_comb begin
    rd_data = 8'h00;
    unique case (ibus.addr[2:0])
      3'd0: rd_data = src_q[7:0];
      3'd1: rd_data = src_q[15:8];
      3'd2: rd_data = dst_q[7:0];
      3'd3: rd_data = dst_q[15:8];
      3'd4: rd_data = cnt_q[7:0];
      3'd5: rd_data = cnt_q[15:8];
      3'd6: rd_data = {(state_q != S_IDLE), 6'b0, arm_q};
      default: ;
    endcase
  end
`else
  assign rd_data = 8'hFF;
`endif

  assign obus = '{dslave: rd_data, mwait: 1'b1};

endmodule

// File: tb/tb_dkong_dma.sv
// -----------------------------------------------------------------------------
// tb_dkong_dma : self-checking bench for dkong_dma.
// A byte-array slave memory feeds reads; a bus monitor logs every read and
// write strobe. Expected traffic is computed from the programmed SRC/DST/CNT
// with plain 16-bit arithmetic and compared against the logs.
// -----------------------------------------------------------------------------
module tb_dkong_dma;
  import z80_bus_pkg::*;

  localparam int RD_CYCLES   = 2;
  localparam int WR_CYCLES   = 2;
  localparam int BYTE_CYCLES = RD_CYCLES + 1 + WR_CYCLES + 1;

  logic        masterclk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        ena       = 1'b0;
  logic        dma_rdy   = 1'b0;
  logic        busak_n   = 1'b1;
  logic        busrq_n, msel, done;
  Z80MasterBus ibus;
  Z80MasterBus mbus;
  Z80SlaveBus  obus;
  Z80SlaveBus  sbus;

  always #5 masterclk = ~masterclk;

  dkong_dma #(.RD_CYCLES(RD_CYCLES), .WR_CYCLES(WR_CYCLES)) dut (
    .masterclk (masterclk),
    .rst_n     (rst_n),
    .ena       (ena),
    .ibus      (ibus),
    .obus      (obus),
    .dma_rdy   (dma_rdy),
    .busrq_n   (busrq_n),
    .busak_n   (busak_n),
    .mbus      (mbus),
    .sbus      (sbus),
    .msel      (msel),
    .done      (done)
  );

  // ---------------- slave memory ----------------
  logic [7:0] mem [65536];
  logic       slave_wait = 1'b1;
  logic       ovr_en     = 1'b0;
  logic [7:0] ovr_data   = 8'h00;
  logic       inject_wait = 1'b0;

  assign sbus = '{dslave: ovr_en ? ovr_data : mem[mbus.addr], mwait: slave_wait};

  // Wait injection: on the first rdn-low cycle, stall for 5 cycles while
  // presenting wrong data, then release with the real memory byte.
  initial begin
    forever begin
      @(negedge masterclk);
      if (inject_wait && !mbus.rdn) begin
        inject_wait = 1'b0;
        slave_wait  = 1'b0;
        ovr_data    = ~mem[mbus.addr];
        ovr_en      = 1'b1;
        repeat (5) @(negedge masterclk);
        slave_wait  = 1'b1;
        ovr_en      = 1'b0;
      end
    end
  end

  // ---------------- CPU bus grant ----------------
  int grant_delay = 3;
  int req_cycles  = 0;
  initial begin
    forever begin
      @(negedge masterclk);
      if (busrq_n) begin
        req_cycles = 0;
        busak_n    = 1'b1;
      end else begin
        req_cycles++;
        if (req_cycles > grant_delay) busak_n = 1'b0;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int          mon_cyc = 0;
  logic        prev_rdn = 1'b1, prev_wrn = 1'b1, prev_done = 1'b0;
  int          rd_len = 0, wr_len = 0, done_run = 0, rd_rise_cyc = 0;
  logic [15:0] rd_addr_q [$];
  int          rd_len_q  [$];
  int          rd_start_q[$];
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int          wr_len_q  [$];
  int          gap_q     [$];
  int          done_len_q[$];
  int          overlap = 0, msel_bad = 0, busrq_low = 0;

  always @(negedge masterclk) begin
    mon_cyc++;
    if (!mbus.rdn && !mbus.wrn) overlap++;
    if ((!mbus.rdn || !mbus.wrn) && !msel) msel_bad++;
    if (!busrq_n) busrq_low++;
    if (!mbus.rdn) begin
      if (prev_rdn) begin
        rd_addr_q.push_back(mbus.addr);
        rd_start_q.push_back(mon_cyc);
        rd_len = 0;
      end
      rd_len++;
    end else if (!prev_rdn) begin
      rd_len_q.push_back(rd_len);
      rd_rise_cyc = mon_cyc;
    end
    if (!mbus.wrn) begin
      if (prev_wrn) begin
        wr_addr_q.push_back(mbus.addr);
        wr_data_q.push_back(mbus.dmaster);
        gap_q.push_back(mon_cyc - rd_rise_cyc);
        wr_len = 0;
      end
      wr_len++;
    end else if (!prev_wrn) begin
      wr_len_q.push_back(wr_len);
    end
    if (done) done_run++;
    else if (prev_done) begin
      done_len_q.push_back(done_run);
      done_run = 0;
    end
    prev_rdn  = mbus.rdn;
    prev_wrn  = mbus.wrn;
    prev_done = done;
  end

  // ---------------- checking ----------------
  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] model);
`ifdef DKONG_DMA_READBACK_EN
    return model;
`else
    return (model === 8'hxx) ? 8'h00 : 8'hFF;
`endif
  endfunction

  task automatic step();
    @(posedge masterclk);
    #2;
  endtask

  task automatic clear_logs();
    rd_addr_q.delete(); rd_len_q.delete(); rd_start_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_len_q.delete();
    gap_q.delete(); done_len_q.delete();
    overlap = 0; msel_bad = 0; busrq_low = 0; done_run = 0;
  endtask

  task automatic cpu_write(input logic [2:0] off, input logic [7:0] data);
    ena = 1'b1; ibus.addr = {13'h0, off}; ibus.dmaster = data; ibus.wrn = 1'b0;
    step();
    ena = 1'b0; ibus.wrn = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] off, output logic [7:0] data);
    ena = 1'b1; ibus.addr = {13'h0, off}; ibus.rdn = 1'b0;
    #1;
    data = obus.dslave;
    ena = 1'b0; ibus.rdn = 1'b1;
  endtask

  task automatic check_regs(input string tag, input logic [15:0] src, dst, cnt,
                            input logic [7:0] ctrl);
    logic [7:0] model [8];
    logic [7:0] d;
    model = '{src[7:0], src[15:8], dst[7:0], dst[15:8], cnt[7:0], cnt[15:8], ctrl, 8'h00};
    for (int i = 0; i < 8; i++) begin
      cpu_read(3'(i), d);
      check($sformatf("%s reg%0d", tag, i), d, exp_rd(model[i]));
    end
  endtask

  task automatic start_transfer(input logic [15:0] src, dst, cnt, input int gd);
    grant_delay = gd;
    clear_logs();
    cpu_write(3'd0, src[7:0]);  cpu_write(3'd1, src[15:8]);
    cpu_write(3'd2, dst[7:0]);  cpu_write(3'd3, dst[15:8]);
    cpu_write(3'd4, cnt[7:0]);  cpu_write(3'd5, cnt[15:8]);
    cpu_write(3'd6, 8'h01);
    dma_rdy = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int snap;
    for (int i = 0; i < budget && done_len_q.size() == 0; i++) step();
    check({tag, " done_seen"}, done_len_q.size() > 0, 1);
    // ARM must have been cleared: dma_rdy still high must not restart.
    snap = busrq_low;
    repeat (6) step();
    check({tag, " no_rearm"}, busrq_low - snap, 0);
    dma_rdy = 1'b0;
  endtask

  // Expected traffic: byte i is read at SRC+i and written to DST+i (16-bit
  // wrap) with the memory byte at SRC+i; every strobe and gap has fixed length.
  task automatic verify(input string tag, input logic [15:0] src, dst,
                        input int cnt, input int extra);
    logic [15:0] ra, wa;
    check({tag, " rd_count"}, rd_addr_q.size(), cnt);
    check({tag, " wr_count"}, wr_addr_q.size(), cnt);
    for (int i = 0; i < cnt; i++) begin
      ra = src + 16'(i);
      wa = dst + 16'(i);
      if (i < rd_addr_q.size()) begin
        check($sformatf("%s rd_addr[%0d]", tag, i), rd_addr_q[i], ra);
        check($sformatf("%s rd_len[%0d]", tag, i), rd_len_q[i],
              RD_CYCLES + ((i == 0) ? extra : 0));
      end
      if (i < wr_addr_q.size()) begin
        check($sformatf("%s wr_addr[%0d]", tag, i), wr_addr_q[i], wa);
        check($sformatf("%s wr_data[%0d]", tag, i), wr_data_q[i], mem[ra]);
        check($sformatf("%s wr_len[%0d]", tag, i), wr_len_q[i], WR_CYCLES);
        check($sformatf("%s gap[%0d]", tag, i), gap_q[i], 1);
      end
      if (i > 0 && i < rd_start_q.size())
        check($sformatf("%s period[%0d]", tag, i), rd_start_q[i] - rd_start_q[i-1],
              BYTE_CYCLES + ((i == 1) ? extra : 0));
    end
    check({tag, " overlap"}, overlap, 0);
    check({tag, " msel_own"}, msel_bad, 0);
    check({tag, " done_pulses"}, done_len_q.size(), 1);
    if (done_len_q.size() > 0) check({tag, " done_len"}, done_len_q[0], 1);
  endtask

  task automatic full_run(input string tag, input logic [15:0] src, dst, cnt,
                          input int gd, input int extra);
    start_transfer(src, dst, cnt, gd);
    wait_done(tag, int'(cnt) * (BYTE_CYCLES + 1) + gd + 60);
    verify(tag, src, dst, int'(cnt), extra);
    check_regs({tag, " post"}, src + cnt, dst + cnt, 16'h0000, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  d;
    logic [15:0] s, t, c;
    int          waited;

    ibus = '{addr: 16'h0, dmaster: 8'h0, rdn: 1'b1, wrn: 1'b1, inta: 1'b1};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Reset state
    #3;
    check("rst busrq_n", busrq_n, 1);
    check("rst msel", msel, 0);
    check("rst done", done, 0);
    check("rst rdn", mbus.rdn, 1);
    check("rst wrn", mbus.wrn, 1);
    check("rst addr", mbus.addr, 16'h0000);
    check("rst dmaster", mbus.dmaster, 8'h00);
    check("rst inta", mbus.inta, 1);
    check("rst obus_mwait", obus.mwait, 1);
    step(); step();
    rst_n = 1'b1;
    step();
    cpu_write(3'd7, 8'hAA);
    check_regs("rst", 16'h0000, 16'h0000, 16'h0000, 8'h00);

    // Long block copy with a 3-cycle grant delay
    full_run("blk", 16'h6900, 16'h7000, 16'h0180, 3, 0);
    if (wr_addr_q.size() > 0) check("blk last_wr", wr_addr_q[$], 16'h717F);
    check("blk idle_addr_hold", mbus.addr, 16'h717F);

    // Address wrap at FFFFh
    full_run("wrap", 16'hFFFF, 16'h0010, 16'h0002, 1, 0);

    // Randomised transfers
    for (int k = 0; k < 3; k++) begin
      s = 16'($urandom); t = 16'($urandom); c = 16'($urandom_range(1, 24));
      full_run($sformatf("rnd%0d", k), s, t, c, $urandom_range(0, 6), 0);
    end

    // Slave wait during the first read
    inject_wait = 1'b1;
    full_run("wait", 16'($urandom), 16'h2000, 16'h0002, 2, 5);

    // Empty transfer: never granted, still completes
    start_transfer(16'h1234, 16'h5678, 16'h0000, 1000);
    wait_done("cnt0", 40);
    check("cnt0 busrq_pulse", busrq_low > 0, 1);
    verify("cnt0", 16'h1234, 16'h5678, 0, 0);
    check_regs("cnt0 post", 16'h1234, 16'h5678, 16'h0000, 8'h00);

    // CPU write while in REQ is ignored
    start_transfer(16'h3000, 16'h4010, 16'h0003, 15);
    waited = 0;
    while (busrq_n && waited < 20) begin step(); waited++; end
    check("req entered", busrq_n, 0);
    cpu_write(3'd2, 8'h55);
    cpu_read(3'd2, d);
    check("req dst_lo_kept", d, exp_rd(8'h10));
    cpu_read(3'd6, d);
    check("req ctrl_busy", d, exp_rd(8'h81));
    wait_done("reqw", 100);
    verify("reqw", 16'h3000, 16'h4010, 3, 0);

    // Reset asserted during a write strobe
    start_transfer(16'h0100, 16'h0800, 16'h000A, 2);
    waited = 0;
    while (mbus.wrn && waited < 100) begin step(); waited++; end
    check("midrst in_wr", mbus.wrn, 0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst wrn", mbus.wrn, 1);
    check("midrst rdn", mbus.rdn, 1);
    check("midrst busrq_n", busrq_n, 1);
    check("midrst msel", msel, 0);
    check("midrst addr", mbus.addr, 16'h0000);
    step(); step();
    rst_n = 1'b1;
    step();
    clear_logs();
    check_regs("midrst", 16'h0000, 16'h0000, 16'h0000, 8'h00);
    repeat (10) step();
    check("midrst no_restart", busrq_low, 0);
    dma_rdy = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dkong_dma.md
DKONG_DMA -- requirements
Module: dkong_dma

Interface
REQ-001 Parameter: RD_CYCLES, default 2, masterclk cycles rdn is held low per read strobe (min 1).
REQ-002 Parameter: WR_CYCLES, default 2, masterclk cycles wrn is held low per write strobe (min 1).
REQ-003 masterclk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ena  in  1  register-window select from the address decoder; offset = ibus.addr[2:0].
REQ-006 ibus  in  Z80MasterBus  shared master bus (CPU register accesses).
REQ-007 obus  out  Z80SlaveBus  register read data and wait for the CPU.
REQ-008 dma_rdy  in  1  transfer request level from the bitmapped IO latch.
REQ-009 busrq_n  out  1  bus request to the CPU, active low.
REQ-010 busak_n  in  1  bus acknowledge from the CPU, active low.
REQ-011 mbus  out  Z80MasterBus  DMA master bus (addr, dmaster, rdn, wrn, inta).
REQ-012 sbus  in  Z80SlaveBus  shared slave bus (read data and wait).
REQ-013 msel  out  1  high while the DMA owns the bus; drives the sysmux master select.
REQ-014 done  out  1  one-cycle pulse when a transfer completes.

Function
REQ-015 Registers by offset: 0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI, 4 CNT_LO, 5 CNT_HI, 6 CTRL (bit0 ARM); 7 is reserved (write ignored, read 00h).
REQ-016 A register write occurs on every cycle with ena=1 and ibus.wrn=0, only in IDLE; writes in any other state are ignored.
REQ-017 A CTRL read returns {BUSY, 6'b0, ARM}, with BUSY=1 in any state other than IDLE.
REQ-018 obus.mwait is constantly 1.
REQ-019 FSM states: IDLE, REQ, RD, WR, NEXT, REL.
REQ-020 IDLE->REQ when ARM=1 and dma_rdy=1; busrq_n goes low on entry to REQ.
REQ-021 REQ->RD when busak_n=0 is sampled; msel goes high in the same cycle.
REQ-022 RD: mbus.addr=SRC, rdn low for RD_CYCLES cycles; the count is extended while sbus.mwait=0; sbus.dslave is latched on the last rdn-low cycle.
REQ-023 WR: mbus.addr=DST, mbus.dmaster=latched byte, wrn low for WR_CYCLES cycles; the count is extended while sbus.mwait=0.
REQ-024 rdn and wrn are never low at the same time; there is 1 idle cycle (both high) between RD and WR.
REQ-025 NEXT: SRC+1, DST+1 (16-bit, FFFFh wraps to 0000h), CNT-1; go to RD if CNT after decrement is nonzero, else go to REL.
REQ-026 REL: busrq_n=1, msel=0, ARM cleared, done pulsed for 1 cycle, then IDLE.
REQ-027 If CNT=0 at start, the block goes IDLE->REQ->REL without performing any bus cycle, and done still pulses.
REQ-028 Deasserting dma_rdy mid-transfer has no effect; the transfer runs to completion.
REQ-029 mbus.inta=1 always; in IDLE, mbus.rdn and mbus.wrn are 1 and mbus.addr holds its last value.
REQ-030 Per-byte latency: RD_CYCLES + 1 + WR_CYCLES + 1 cycles plus any wait extension.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE, busrq_n=1, msel=0, done=0, mbus.rdn=1, mbus.wrn=1, mbus.addr=0000h, mbus.dmaster=00h, all registers=0.
REQ-032 Reset asserted mid-transfer releases the bus immediately; no partial write strobe continues after reset.

Configuration
REQ-033 Macro DKONG_DMA_READBACK_EN: when defined, register reads return the values in REQ-015/017; when undefined, obus.dslave=FFh for every offset and the read mux is omitted.

Verification
REQ-034 Program SRC=6900h, DST=7000h, CNT=0180h, ARM=1; raise dma_rdy; grant the bus after 3 cycles -> 384 read/write pairs, last write to 717Fh, one done pulse, ARM reads 0.
REQ-035 SRC=FFFFh, DST=0010h, CNT=2 -> reads at FFFFh then 0000h; writes at 0010h then 0011h.
REQ-036 Slave holds sbus.mwait=0 for 5 cycles during the first read -> rdn stays low RD_CYCLES+5 cycles; the latched data equals the value present after wait is released.
REQ-037 CNT=0, ARM=1, dma_rdy=1 -> busrq_n pulses low, no rdn/wrn strobes, done=1 for 1 cycle.
REQ-038 CPU write of DST_LO=55h while in REQ -> ignored; DST_LO reads back its old value (with READBACK_EN defined).
REQ-039 rst_n low during WR -> wrn=1, busrq_n=1, msel=0 asynchronously; after release all registers read 00h.
